// File: rtl/c499_sec_encoder.sv
// Streaming SEC encoder producing the 8 c499 check bits for a 32-bit word, behind a 2-stage valid/ready pipeline.
// Optional feature macro: ERR_INJECT_EN (adds inj_en/inj_idx single-bit fault injection on the codeword).
module c499_sec_encoder #(
    parameter int CNT_W = 16
`ifdef ERR_INJECT_EN
    ,
    parameter int INJ_IDX_W = 6
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_check,
    output logic [CNT_W-1:0] word_cnt
`ifdef ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [INJ_IDX_W-1:0] inj_idx
`endif
);

    logic             s1_v_q, s1_v_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic [7:0]       s1_nib_q, s1_nib_d;
    logic [3:0]       s1_col_q, s1_col_d;
    logic [39:0]      s1_flip_q, s1_flip_d;

    logic             s2_v_q, s2_v_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [7:0]       s2_check_q, s2_check_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             s2_load;
    logic             s1_move;
    logic             emit;
    logic [3:0]       col_hi;
    logic [3:0]       col_lo;
    logic [7:0]       check;

    // Handshake: S2 can take a word when empty or draining; S1 can take one when empty or moving into S2.
    always_comb begin
        s2_load  = !s2_v_q || out_ready;
        s1_move  = s1_v_q && s2_load;
        in_ready = !s1_v_q || s2_load;
        accept   = in_valid && in_ready;
        emit     = s2_v_q && out_ready;
    end

    // Stage 1: nibble parities n[j] = ^d[4j+3:4j] and full-width column parities over d[i], d[i+4], ...
    always_comb begin
        s1_v_d    = accept || (s1_v_q && !s1_move);
        s1_data_d = s1_data_q;
        s1_nib_d  = s1_nib_q;
        s1_col_d  = s1_col_q;
        s1_flip_d = s1_flip_q;
        if (accept) begin
            s1_data_d = in_data;
            for (int j = 0; j < 8; j++) begin
                s1_nib_d[j] = ^in_data[4*j +: 4];
            end
            for (int i = 0; i < 4; i++) begin
                s1_col_d[i] = in_data[i]      ^ in_data[i + 4]  ^ in_data[i + 8]  ^ in_data[i + 12] ^
                              in_data[i + 16] ^ in_data[i + 20] ^ in_data[i + 24] ^ in_data[i + 28];
            end
            s1_flip_d = '0;
`ifdef ERR_INJECT_EN
            if (inj_en && (32'(inj_idx) < 32'd40)) begin
                s1_flip_d = 40'(1) << inj_idx;
            end
`endif
        end
    end

    // Stage 2: split column parities into upper/lower half and fold in the nibble parities.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            col_hi[i] = s1_data_q[i + 16] ^ s1_data_q[i + 20] ^ s1_data_q[i + 24] ^ s1_data_q[i + 28];
            col_lo[i] = s1_col_q[i] ^ col_hi[i];
        end
        check[0] = col_lo[0] ^ s1_nib_q[4] ^ s1_nib_q[5];
        check[1] = col_lo[1] ^ s1_nib_q[6] ^ s1_nib_q[7];
        check[2] = col_lo[2] ^ s1_nib_q[4] ^ s1_nib_q[6];
        check[3] = col_lo[3] ^ s1_nib_q[5] ^ s1_nib_q[7];
        check[4] = col_hi[0] ^ s1_nib_q[0] ^ s1_nib_q[1];
        check[5] = col_hi[1] ^ s1_nib_q[2] ^ s1_nib_q[3];
        check[6] = col_hi[2] ^ s1_nib_q[0] ^ s1_nib_q[2];
        check[7] = col_hi[3] ^ s1_nib_q[1] ^ s1_nib_q[3];

        s2_v_d     = s2_load ? s1_v_q : s2_v_q;
        s2_data_d  = s2_data_q;
        s2_check_d = s2_check_q;
        if (s1_move) begin
            {s2_check_d, s2_data_d} = {check, s1_data_q} ^ s1_flip_q;
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, emit};
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s1_nib_q   <= '0;
            s1_col_q   <= '0;
            s1_flip_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_data_q  <= '0;
            s2_check_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            s1_nib_q   <= s1_nib_d;
            s1_col_q   <= s1_col_d;
            s1_flip_q  <= s1_flip_d;
            s2_v_q     <= s2_v_d;
            s2_data_q  <= s2_data_d;
            s2_check_q <= s2_check_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_check = s2_check_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Randomized bench for c499_sec_encoder: mask-based check-bit model, expected-word queue and a c499 syndrome decoder.
module tb_c499_sec_encoder;

    localparam int CNT_W = 4;

    typedef struct {
        logic        ok;
        logic [31:0] d;
        logic [7:0]  c;
    } word_t;

    // Data bits participating in each check bit, read directly off the c499 check equations.
    localparam logic [31:0] MASK [8] = '{
        32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
        32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
    };

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [7:0]       out_check;
    logic [CNT_W-1:0] word_cnt;
`ifdef ERR_INJECT_EN
    logic             inj_en = 1'b0;
    logic [5:0]       inj_idx = '0;
`endif

    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_cnt = 0;
    word_t exp_q[$];

    c499_sec_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_check (out_check),
        .word_cnt  (word_cnt)
`ifdef ERR_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_idx   (inj_idx)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_check(input logic [31:0] d);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) c[i] = ^(d & MASK[i]);
        return c;
    endfunction

    // c499 corrector model: returns number of corrected positions, and the last one (0-31 data, 32-39 check).
    function automatic int c499_fix(input logic [31:0] d, input logic [7:0] c, output int pos);
        logic [7:0] syn;
        logic [7:0] col;
        int         n;
        syn = c ^ ref_check(d);
        n   = 0;
        pos = -1;
        if (syn != 8'h00) begin
            for (int k = 0; k < 40; k++) begin
                for (int i = 0; i < 8; i++) col[i] = (k < 32) ? MASK[i][k] : (k - 32 == i);
                if (col == syn) begin
                    n++;
                    pos = k;
                end
            end
        end
        return n;
    endfunction

    function automatic word_t pop_exp();
        word_t w;
        w.ok = 1'b0;
        w.d  = '0;
        w.c  = '0;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        return w;
    endfunction

    // One clock: drive at negedge, sample just after, log accepted words into the expected queue.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic ordy,
                               output logic acc, output logic ov,
                               output logic [31:0] od, output logic [7:0] oc);
        word_t       w;
        logic [39:0] cw;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        ov  = out_valid;
        od  = out_data;
        oc  = out_check;
        if (acc) begin
            cw = {ref_check(d), d};
`ifdef ERR_INJECT_EN
            if (inj_en && inj_idx < 6'd40) cw[inj_idx] = ~cw[inj_idx];
`endif
            w.ok = 1'b1;
            w.d  = cw[31:0];
            w.c  = cw[39:32];
            exp_q.push_back(w);
        end
        if (ov && ordy) exp_cnt++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_tests++; if (out_check !== 8'h00) begin n_fail++; $display("FAIL reset_out_check: got %h want 00", out_check); end
        n_tests++; if (word_cnt !== '0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    endtask

    task automatic test_vectors();
        logic [31:0] vd [5] = '{32'h00000000, 32'h00000001, 32'h00010000, 32'h80000000, 32'hFFFFFFFF};
        logic [7:0]  vc [5] = '{8'h00, 8'h51, 8'h15, 8'h8A, 8'h00};
        logic        acc, ov;
        logic [31:0] od;
        logic [7:0]  oc;
        word_t       w;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, vd[i], 1'b1, acc, ov, od, oc);
            n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL vec%0d_accept: got %b want 1", i, acc); end
            drive_cycle(1'b0, '0, 1'b1, acc, ov, od, oc);
            n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %b want 0", i, ov); end
            drive_cycle(1'b0, '0, 1'b1, acc, ov, od, oc);
            w = pop_exp();
            n_tests++;
            if (ov !== 1'b1 || od !== vd[i] || oc !== vc[i] || !w.ok) begin
                n_fail++;
                $display("FAIL vec%0d_codeword: got v=%b %h/%h want v=1 %h/%h", i, ov, od, oc, vd[i], vc[i]);
            end
            #1;
            n_tests++; if (word_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL vec%0d_word_cnt: got %0d want %0d", i, word_cnt, CNT_W'(exp_cnt)); end
        end
    endtask

    task automatic test_back_to_back();
        logic        acc, ov;
        logic [31:0] od;
        logic [7:0]  oc;
        word_t       w;
        int          pos;
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive_cycle(cyc < 8, $urandom, 1'b1, acc, ov, od, oc);
            if (cyc < 8) begin
                n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d: got %b want 1", cyc, acc); end
            end
            n_tests++;
            if (ov !== (cyc >= 2 && cyc < 10)) begin
                n_fail++; $display("FAIL b2b_valid%0d: got %b want %b", cyc, ov, (cyc >= 2 && cyc < 10));
            end
            if (ov) begin
                w = pop_exp();
                n_tests++;
                if (!w.ok || od !== w.d || oc !== w.c) begin
                    n_fail++; $display("FAIL b2b_word%0d: got %h/%h want %h/%h", cyc, od, oc, w.d, w.c);
                end
                n_tests++;
                if (c499_fix(od, oc, pos) != 0) begin
                    n_fail++; $display("FAIL b2b_c499%0d: got correction at %0d want none", cyc, pos);
                end
            end
        end
        #1;
        n_tests++; if (word_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL b2b_word_cnt: got %0d want %0d", word_cnt, CNT_W'(exp_cnt)); end
    endtask

    task automatic test_stall();
        logic        acc, ov;
        logic [31:0] od, hold_d;
        logic [7:0]  oc, hold_c;
        word_t       w;
        hold_d = '0;
        hold_c = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive_cycle(1'b1, $urandom, 1'b0, acc, ov, od, oc);
            n_tests++; if (acc !== (cyc < 2)) begin n_fail++; $display("FAIL stall_accept%0d: got %b want %b", cyc, acc, (cyc < 2)); end
            if (cyc == 2) begin
                hold_d = od;
                hold_c = oc;
                n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", ov); end
            end else if (cyc > 2) begin
                n_tests++;
                if (ov !== 1'b1 || od !== hold_d || oc !== hold_c) begin
                    n_fail++; $display("FAIL stall_hold%0d: got %b %h/%h want 1 %h/%h", cyc, ov, od, oc, hold_d, hold_c);
                end
            end
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive_cycle(cyc < 3, $urandom, 1'b1, acc, ov, od, oc);
            if (cyc < 3) begin
                n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL drain_accept%0d: got %b want 1", cyc, acc); end
            end
            if (ov) begin
                w = pop_exp();
                n_tests++;
                if (!w.ok || od !== w.d || oc !== w.c) begin
                    n_fail++; $display("FAIL drain_word%0d: got %h/%h want %h/%h", cyc, od, oc, w.d, w.c);
                end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_lost: got %0d undelivered want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic        acc, ov;
        logic [31:0] od;
        logic [7:0]  oc;
        drive_cycle(1'b1, $urandom | 32'h1, 1'b0, acc, ov, od, oc);
        drive_cycle(1'b1, $urandom | 32'h1, 1'b0, acc, ov, od, oc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_check !== 8'h00 || word_cnt !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got v=%b %h/%h cnt=%0d want all 0", out_valid, out_data, out_check, word_cnt);
        end
        exp_q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive_cycle(1'b0, '0, 1'b1, acc, ov, od, oc);
            n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d: got valid %b want 0", cyc, ov); end
        end
    endtask

    task automatic test_cnt_wrap();
        logic        acc, ov;
        logic [31:0] od;
        logic [7:0]  oc;
        word_t       w;
        for (int cyc = 0; cyc < 22; cyc++) begin
            drive_cycle(cyc < 20, $urandom, 1'b1, acc, ov, od, oc);
            if (ov) begin
                w = pop_exp();
                n_tests++;
                if (!w.ok || od !== w.d || oc !== w.c) begin
                    n_fail++; $display("FAIL wrap_word%0d: got %h/%h want %h/%h", cyc, od, oc, w.d, w.c);
                end
            end
            #1;
            n_tests++; if (word_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL wrap_cnt%0d: got %0d want %0d", cyc, word_cnt, CNT_W'(exp_cnt)); end
        end
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_inject();
        logic [31:0] vd   [4] = '{32'h0, 32'h0, 32'h0, 32'h12345678};
        logic        ven  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [5:0]  vidx [4] = '{6'd5, 6'd5, 6'd45, 6'd35};
        logic        acc, ov;
        logic [31:0] od;
        logic [7:0]  oc;
        word_t       w;
        int          pos, n;
        for (int i = 0; i < 4; i++) begin
            inj_en  = ven[i];
            inj_idx = vidx[i];
            drive_cycle(1'b1, vd[i], 1'b1, acc, ov, od, oc);
            inj_en = 1'b0;
            drive_cycle(1'b0, '0, 1'b1, acc, ov, od, oc);
            drive_cycle(1'b0, '0, 1'b1, acc, ov, od, oc);
            w = pop_exp();
            n_tests++;
            if (ov !== 1'b1 || !w.ok || od !== w.d || oc !== w.c) begin
                n_fail++; $display("FAIL inj%0d_word: got %h/%h want %h/%h", i, od, oc, w.d, w.c);
            end
            n = c499_fix(od, oc, pos);
            if (i == 0) begin
                n_tests++;
                if (od !== 32'h20 || oc !== 8'h00 || n != 1 || pos != 5) begin
                    n_fail++; $display("FAIL inj_bit5: got %h/%h fix n=%0d pos=%0d want 00000020/00 n=1 pos=5", od, oc, n, pos);
                end
            end else if (i == 3) begin
                n_tests++; if (n != 1 || pos != 35) begin n_fail++; $display("FAIL inj_check3: got n=%0d pos=%0d want n=1 pos=35", n, pos); end
            end else begin
                n_tests++; if (n != 0) begin n_fail++; $display("FAIL inj%0d_clean: got correction at %0d want none", i, pos); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_cnt_wrap();
`ifdef ERR_INJECT_EN
        test_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
